tiger_checkpoint_ctrl: RTL and testbench

- Initiator side of the core's checkpoint/rollback handshake. Decides when architectural state is checkpointed and when it is rolled back.
- Drives `checkpoint` / `checkpointdone` / `poweron` into the decode stage (register file and branch/PC unit), and stalls the pipeline while a checkpoint drains.
- Triggers: a periodic timer, a brownout warning, and supply loss/return.

---
 rtl/tiger_checkpoint_ctrl.sv | 151 +++++++++++++++
 tb/tb_tiger_checkpoint_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tiger_checkpoint_ctrl.sv
// Checkpoint/rollback initiator. Decides when architectural state is checkpointed
// (periodic timer or brownout) and when it is restored after supply loss.
module tiger_checkpoint_ctrl #(
   parameter int unsigned CKPT_PERIOD    = 1000,
   parameter int unsigned DRAIN_TIMEOUT  = 16,
   parameter int unsigned RESTORE_CYCLES = 2,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 power_good,
   input  logic                 voltage_low,
   input  logic                 ckpt_enable,
   input  logic                 pipe_idle,
   output logic                 stall_req,
   output logic                 checkpoint,
   output logic                 checkpointdone,
   output logic                 poweron,
   output logic                 ckpt_abort,
   output logic                 ckpt_valid,
   output logic [CNT_WIDTH-1:0] ckpt_count
);

   localparam int unsigned PER_W = (CKPT_PERIOD    > 1) ? $clog2(CKPT_PERIOD)    : 1;
   localparam int unsigned DRN_W = (DRAIN_TIMEOUT  > 1) ? $clog2(DRAIN_TIMEOUT)  : 1;
   localparam int unsigned RST_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(CKPT_PERIOD - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESTORE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_RESTORE,
      S_RUN,
      S_DRAIN,
      S_COMMIT
   } state_t;

   state_t               state, state_nx;
   logic [PER_W-1:0]     period_cnt, period_cnt_nx;
   logic [DRN_W-1:0]     drain_cnt, drain_cnt_nx;
   logic [RST_W-1:0]     restore_cnt, restore_cnt_nx;
   logic                 stall_nx, checkpoint_nx, done_nx, poweron_nx, abort_nx;
   logic                 valid_nx;
   logic [CNT_WIDTH-1:0] count_nx;
   logic                 trigger;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_OFF;
      else          state <= state_nx;
   end

   assign trigger = (ckpt_enable && (period_cnt == PER_LAST)) || voltage_low;

   // Next-state, counter and output decode
   always_comb begin
      state_nx       = state;
      period_cnt_nx  = period_cnt;
      drain_cnt_nx   = drain_cnt;
      restore_cnt_nx = restore_cnt;
      valid_nx       = ckpt_valid;
      count_nx       = ckpt_count;
      stall_nx       = 1'b1;
      checkpoint_nx  = 1'b0;
      done_nx        = 1'b0;
      poweron_nx     = 1'b0;
      abort_nx       = 1'b0;

      case (state)
         S_OFF: begin
            if (power_good) begin
               state_nx       = ckpt_valid ? S_RESTORE : S_RUN;
               restore_cnt_nx = '0;
            end
         end
         S_RESTORE: begin
            period_cnt_nx = '0;
            if (restore_cnt == RST_LAST) state_nx = S_RUN;
            else                         restore_cnt_nx = restore_cnt + RST_W'(1);
         end
         S_RUN: begin
            if (trigger) begin
               state_nx      = S_DRAIN;
               period_cnt_nx = '0;
               drain_cnt_nx  = '0;
            end else if (ckpt_enable) begin
               period_cnt_nx = period_cnt + PER_W'(1);
            end
         end
         S_DRAIN: begin
            if (pipe_idle)                  state_nx = S_COMMIT;
            else if (drain_cnt == DRN_LAST) state_nx = S_RUN;
            else                            drain_cnt_nx = drain_cnt + DRN_W'(1);
         end
         S_COMMIT: state_nx = S_RUN;
         default:  state_nx = S_OFF;
      endcase

      // Supply loss overrides every other event, abandoning any checkpoint
      if (!power_good) state_nx = S_OFF;

      abort_nx = (state == S_DRAIN) && (state_nx == S_RUN);

      // Commit bookkeeping lands together with the checkpointdone pulse
      if (state_nx == S_COMMIT) begin
         valid_nx = 1'b1;
         count_nx = ckpt_count + CNT_WIDTH'(1);
      end

      case (state_nx)
         S_RESTORE: poweron_nx = 1'b1;
         S_RUN:     stall_nx = 1'b0;
         S_DRAIN:   checkpoint_nx = 1'b1;
         S_COMMIT: begin
            checkpoint_nx = 1'b1;
            done_nx       = 1'b1;
         end
         default: ;
      endcase
   end

   // Counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt     <= '0;
         drain_cnt      <= '0;
         restore_cnt    <= '0;
         stall_req      <= 1'b1;
         checkpoint     <= 1'b0;
         checkpointdone <= 1'b0;
         poweron        <= 1'b0;
         ckpt_abort     <= 1'b0;
         ckpt_valid     <= 1'b0;
         ckpt_count     <= '0;
      end else begin
         period_cnt     <= period_cnt_nx;
         drain_cnt      <= drain_cnt_nx;
         restore_cnt    <= restore_cnt_nx;
         stall_req      <= stall_nx;
         checkpoint     <= checkpoint_nx;
         checkpointdone <= done_nx;
         poweron        <= poweron_nx;
         ckpt_abort     <= abort_nx;
         ckpt_valid     <= valid_nx;
         ckpt_count     <= count_nx;
      end
   end

endmodule

// File: tb/tb_tiger_checkpoint_ctrl.sv
// Directed vector bench for tiger_checkpoint_ctrl: per-cycle input/expected-output
// records plus hand-written async reset checks.
module tb_tiger_checkpoint_ctrl;

   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          power_good, voltage_low, ckpt_enable, pipe_idle;
   logic          stall_req, checkpoint, checkpointdone, poweron, ckpt_abort, ckpt_valid;
   logic [CW-1:0] ckpt_count;
   logic [7:0]    act;

   int total = 0;
   int bad   = 0;

   tiger_checkpoint_ctrl #(
      .CKPT_PERIOD   (8),
      .DRAIN_TIMEOUT (4),
      .RESTORE_CYCLES(2),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .power_good    (power_good),
      .voltage_low   (voltage_low),
      .ckpt_enable   (ckpt_enable),
      .pipe_idle     (pipe_idle),
      .stall_req     (stall_req),
      .checkpoint    (checkpoint),
      .checkpointdone(checkpointdone),
      .poweron       (poweron),
      .ckpt_abort    (ckpt_abort),
      .ckpt_valid    (ckpt_valid),
      .ckpt_count    (ckpt_count)
   );

   always #5 clk = ~clk;

   // {stall, checkpoint, done, poweron, abort, valid, count[1:0]}
   assign act = {stall_req, checkpoint, checkpointdone, poweron, ckpt_abort, ckpt_valid, ckpt_count};

   typedef struct packed {
      logic       pg;
      logic       vl;
      logic       en;
      logic       pi;
      logic [7:0] exp;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int n, input logic pg, input logic vl, input logic en,
                      input logic pi, input logic [7:0] e);
      for (int k = 0; k < n; k++) vq.push_back({pg, vl, en, pi, e});
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%b want=%b (stall,ckpt,done,pon,abort,valid,cnt)", name, got, want);
      end
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         power_good  = vq[i].pg;
         voltage_low = vq[i].vl;
         ckpt_enable = vq[i].en;
         pipe_idle   = vq[i].pi;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), act, vq[i].exp);
         total++;
         if (checkpointdone && poweron) begin
            bad++;
            $display("FAIL vec%0d_excl: checkpointdone=%b poweron=%b both high", i,
                     checkpointdone, poweron);
         end
      end
   endtask

   int n1;

   initial begin
      //        n  pg vl en pi   expected
      // Periodic checkpoint: 8 RUN cycles, one DRAIN, one COMMIT
      add(1,  0, 0, 1, 1, 8'b1_0_0_0_0_0_00);
      add(8,  1, 0, 1, 1, 8'b0_0_0_0_0_0_00);
      add(1,  1, 0, 1, 1, 8'b1_1_0_0_0_0_00);
      add(1,  1, 0, 1, 1, 8'b1_1_1_0_0_1_01);
      add(1,  1, 0, 0, 1, 8'b0_0_0_0_0_1_01);
      // Brownout pulse, pipe idle on the 4th (last allowed) DRAIN cycle
      add(1,  1, 1, 0, 0, 8'b1_1_0_0_0_1_01);
      add(3,  1, 0, 0, 0, 8'b1_1_0_0_0_1_01);
      add(1,  1, 0, 0, 1, 8'b1_1_1_0_0_1_10);
      add(1,  1, 0, 0, 0, 8'b0_0_0_0_0_1_10);
      // Timeout abort with voltage_low held, then retrigger and commit
      add(4,  1, 1, 0, 0, 8'b1_1_0_0_0_1_10);
      add(1,  1, 1, 0, 0, 8'b0_0_0_0_1_1_10);
      add(1,  1, 1, 0, 0, 8'b1_1_0_0_0_1_10);
      add(1,  1, 0, 0, 1, 8'b1_1_1_0_0_1_11);
      add(1,  1, 0, 0, 0, 8'b0_0_0_0_0_1_11);
      // Counter wrap 3 -> 0
      add(1,  1, 1, 0, 1, 8'b1_1_0_0_0_1_11);
      add(1,  1, 0, 0, 1, 8'b1_1_1_0_0_1_00);
      add(1,  1, 0, 0, 1, 8'b0_0_0_0_0_1_00);
      // Enable gaps hold the period counter; expiry and brownout coincide
      add(3,  1, 0, 1, 1, 8'b0_0_0_0_0_1_00);
      add(2,  1, 0, 0, 1, 8'b0_0_0_0_0_1_00);
      add(4,  1, 0, 1, 1, 8'b0_0_0_0_0_1_00);
      add(1,  1, 1, 1, 1, 8'b1_1_0_0_0_1_00);
      add(1,  1, 0, 1, 1, 8'b1_1_1_0_0_1_01);
      add(2,  1, 0, 1, 1, 8'b0_0_0_0_0_1_01);
      // Power loss then rollback; voltage_low ignored during RESTORE
      add(5,  0, 0, 0, 0, 8'b1_0_0_0_0_1_01);
      add(1,  1, 0, 0, 0, 8'b1_0_0_1_0_1_01);
      add(1,  1, 1, 0, 0, 8'b1_0_0_1_0_1_01);
      add(2,  1, 0, 0, 0, 8'b0_0_0_0_0_1_01);
      // Power fails on the cycle pipe_idle rises mid-DRAIN
      add(1,  1, 1, 0, 0, 8'b1_1_0_0_0_1_01);
      add(1,  1, 0, 0, 0, 8'b1_1_0_0_0_1_01);
      add(2,  0, 0, 0, 1, 8'b1_0_0_0_0_1_01);
      add(2,  1, 0, 0, 0, 8'b1_0_0_1_0_1_01);
      add(1,  1, 0, 0, 0, 8'b0_0_0_0_0_1_01);
      // Park in DRAIN for the async reset check
      add(1,  1, 1, 0, 0, 8'b1_1_0_0_0_1_01);
      add(1,  1, 0, 0, 0, 8'b1_1_0_0_0_1_01);
      n1 = vq.size();
      // Cold power-up cycles after reset: never poweron
      add(1,  0, 0, 0, 0, 8'b1_0_0_0_0_0_00);
      add(2,  1, 0, 0, 0, 8'b0_0_0_0_0_0_00);
      add(1,  0, 0, 0, 0, 8'b1_0_0_0_0_0_00);
      add(2,  1, 0, 0, 0, 8'b0_0_0_0_0_0_00);

      reset_n     = 1'b0;
      power_good  = 1'b0;
      voltage_low = 1'b0;
      ckpt_enable = 1'b0;
      pipe_idle   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", act, 8'b1_0_0_0_0_0_00);
      @(negedge clk);
      reset_n = 1'b1;

      apply(0, n1);

      // Async reset mid-DRAIN, sampled before the next clock edge
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset", act, 8'b1_0_0_0_0_0_00);
      @(posedge clk);
      #1;
      check("reset_hold", act, 8'b1_0_0_0_0_0_00);
      @(negedge clk);
      reset_n = 1'b1;

      apply(n1, vq.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
